// File: rtl/seg7_mux.sv
// Time-multiplexed hex display driver: shadow-latched digits, per-slot dead cycle,
// optional leading-zero suppression, registered active-low outputs.
module seg7_mux #(
   parameter int DIGITS   = 4,
   parameter int DIV      = 50000,
   parameter bit LZ_BLANK = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] value,
   input  logic [DIGITS-1:0]   dp,
   input  logic [DIGITS-1:0]   blank,
   input  logic                load,
   output logic [6:0]          seg,
   output logic                dp_out,
   output logic [DIGITS-1:0]   an
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic [CW-1:0]       r_cnt;
   logic [IW-1:0]       r_idx;
   logic [4*DIGITS-1:0] r_val;
   logic [DIGITS-1:0]   r_dp;
   logic [DIGITS-1:0]   r_blank;
   logic [6:0]          r_seg;
   logic                r_dp_out;
   logic [DIGITS-1:0]   r_an;

   logic [DIGITS-1:0]   w_lz;
   logic [DIGITS-1:0]   w_an;
   logic [3:0]          w_nib;
   logic                w_dp;
   logic                w_off;
   logic                w_dead;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 7'b1000000;
         4'h1: decode = 7'b1111001;
         4'h2: decode = 7'b0100100;
         4'h3: decode = 7'b0110000;
         4'h4: decode = 7'b0011001;
         4'h5: decode = 7'b0010010;
         4'h6: decode = 7'b0000010;
         4'h7: decode = 7'b1011000;
         4'h8: decode = 7'b0000000;
         4'h9: decode = 7'b0010000;
         4'hA: decode = 7'b0001000;
         4'hB: decode = 7'b0000011;
         4'hC: decode = 7'b1000110;
         4'hD: decode = 7'b0100001;
         4'hE: decode = 7'b0000110;
         default: decode = 7'b0001110;
      endcase
   endfunction

   // Scan from the most significant nibble down; a lit dp keeps its own digit visible.
   always_comb begin : lz_mask
      logic hz;
      hz   = 1'b1;
      w_lz = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         hz      = hz & (r_val[4*i +: 4] == 4'h0);
         w_lz[i] = LZ_BLANK && (i != 0) && hz && !r_dp[i];
      end
   end

   assign w_dead = (r_cnt == '0);

   always_comb begin
      w_nib = 4'h0;
      w_dp  = 1'b0;
      w_off = 1'b0;
      w_an  = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IW'(i)) begin
            w_nib   = r_val[4*i +: 4];
            w_dp    = r_dp[i];
            w_off   = r_blank[i] | w_lz[i];
            w_an[i] = w_dead;
         end
      end
      if (w_off) w_an = '1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_idx    <= '0;
         r_val    <= '0;
         r_dp     <= '0;
         r_blank  <= '0;
         r_seg    <= 7'h7F;
         r_dp_out <= 1'b1;
         r_an     <= '1;
      end else begin
         if (load) begin
            r_val   <= value;
            r_dp    <= dp;
            r_blank <= blank;
         end
         if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
         r_an     <= w_an;
         r_seg    <= (w_off || w_dead) ? 7'h7F : decode(w_nib);
         r_dp_out <= w_off || w_dead || !w_dp;
      end
   end

   assign seg    = r_seg;
   assign dp_out = r_dp_out;
   assign an     = r_an;
endmodule

// File: tb/tb_seg7_mux.sv
// Bench for seg7_mux: two instances (LZ_BLANK 0/1) checked every cycle against a
// slot-position model, plus directed literal checks.
module tb_seg7_mux;
   localparam int D  = 4;
   localparam int DV = 4;

   logic        clk = 1'b0;
   logic        rst, load;
   logic [15:0] value;
   logic [3:0]  dp, blank;
   logic [6:0]  seg0, seg1;
   logic        dpo0, dpo1;
   logic [3:0]  an0, an1;

   int n_chk = 0;
   int n_fail = 0;

   seg7_mux #(.DIGITS(D), .DIV(DV), .LZ_BLANK(1'b0)) dut0 (
      .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .load(load),
      .seg(seg0), .dp_out(dpo0), .an(an0));
   seg7_mux #(.DIGITS(D), .DIV(DV), .LZ_BLANK(1'b1)) dut1 (
      .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .load(load),
      .seg(seg1), .dp_out(dpo1), .an(an1));

   always #5 clk = ~clk;

   logic [6:0] SEGTAB [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   // Model: time since reset release gives slot position directly.
   int          m_t = 0;
   bit          m_vld = 1'b0;
   logic [15:0] m_val;
   logic [3:0]  m_dp, m_blank;
   int          e_idx = -1, e_cnt = -1;
   bit          e_full;
   logic [3:0]  e_an [2];
   logic [6:0]  e_seg [2];
   logic        e_dp [2];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   function automatic void calc(input int lz, output logic [3:0] a,
                                output logic [6:0] s, output logic d);
      logic [3:0] nib;
      logic       off;
      nib = 4'(m_val >> (4 * e_idx));
      off = m_blank[e_idx] ||
            (lz == 1 && e_idx > 0 && (m_val >> (4 * e_idx)) == 16'h0 && !m_dp[e_idx]);
      a = (off || e_cnt == 0) ? 4'hF : ~(4'b0001 << e_idx);
      s = off ? 7'h7F : SEGTAB[nib];
      d = off ? 1'b1 : ~m_dp[e_idx];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_t = 0; m_val = '0; m_dp = '0; m_blank = '0;
         e_idx = -1; e_cnt = -1; e_full = 1'b1; m_vld = 1'b1;
         for (int k = 0; k < 2; k++) begin
            e_an[k] = 4'hF; e_seg[k] = 7'h7F; e_dp[k] = 1'b1;
         end
      end else if (m_vld) begin
         e_cnt  = m_t % DV;
         e_idx  = (m_t / DV) % D;
         e_full = (e_cnt != 0);
         for (int k = 0; k < 2; k++) calc(k, e_an[k], e_seg[k], e_dp[k]);
         m_t++;
         if (load) begin
            m_val = value; m_dp = dp; m_blank = blank;
         end
      end
   end

   always @(negedge clk) begin
      if (m_vld) begin
         chk("an0", 32'(an0), 32'(e_an[0]));
         chk("an1", 32'(an1), 32'(e_an[1]));
         if (e_full) begin
            chk("seg0", 32'(seg0), 32'(e_seg[0]));
            chk("seg1", 32'(seg1), 32'(e_seg[1]));
            chk("dp_out0", 32'(dpo0), 32'(e_dp[0]));
            chk("dp_out1", 32'(dpo1), 32'(e_dp[1]));
         end
         chk("an0_onehot", 32'($countones(~an0) <= 1), 32'(1));
         chk("an1_onehot", 32'($countones(~an1) <= 1), 32'(1));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load_all(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      value = v; dp = d; blank = b; load = 1'b1;
      tick();
      load = 1'b0;
      tick();
   endtask

   // Returns at the negedge whose outputs show the first lit cycle of digit idx.
   task automatic wait_pos(input int idx);
      int n;
      n = 0;
      tick();
      while (!(e_idx == idx && e_cnt == 1) && n < 64) begin
         tick();
         n++;
      end
      if (n >= 64) begin
         n_chk++; n_fail++;
         $display("FAIL wait_pos: digit %0d never reached, required within 64 cycles", idx);
      end
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; value = '0; dp = '0; blank = '0;
      tick(); tick();
      chk("rst_an", 32'(an0), 32'h0000000F);
      chk("rst_seg", 32'(seg0), 32'h0000007F);
      chk("rst_dp", 32'(dpo0), 32'h1);

      // Load 12AF together with reset release
      rst = 1'b0; load = 1'b1; value = 16'h12AF;
      tick();
      chk("dead0", 32'(an0), 32'h0000000F);
      load = 1'b0;
      tick();
      chk("d0_an", 32'(an0), 32'b1110); chk("d0_seg", 32'(seg0), 32'b0001110);
      repeat (4) tick();
      chk("d1_an", 32'(an0), 32'b1101); chk("d1_seg", 32'(seg0), 32'b0001000);
      repeat (4) tick();
      chk("d2_an", 32'(an0), 32'b1011); chk("d2_seg", 32'(seg0), 32'b0100100);
      repeat (4) tick();
      chk("d3_an", 32'(an0), 32'b0111); chk("d3_seg", 32'(seg0), 32'b1111001);

      // Live input changes without load must not reach the display
      load_all(16'h0005, 4'b0000, 4'b0000);
      repeat (20) begin value = 16'($urandom); dp = 4'($urandom); tick(); end
      wait_pos(0);
      chk("hold_seg0", 32'(seg0), 32'b0010010);
      chk("hold_seg1", 32'(seg1), 32'b0010010);

      // Leading-zero suppression
      load_all(16'h0040, 4'b0000, 4'b0000);
      wait_pos(3); chk("lz3_an", 32'(an1), 32'hF); chk("lz3_seg", 32'(seg1), 32'h7F);
      wait_pos(2); chk("lz2_an", 32'(an1), 32'hF); chk("lz2_seg", 32'(seg1), 32'h7F);
      wait_pos(1); chk("lz1_an", 32'(an1), 32'b1101); chk("lz1_seg", 32'(seg1), 32'b0011001);
      wait_pos(0); chk("lz0_an", 32'(an1), 32'b1110); chk("lz0_seg", 32'(seg1), 32'b1000000);
      load_all(16'h0040, 4'b0100, 4'b0000);
      wait_pos(2);
      chk("lzdp_an", 32'(an1), 32'b1011); chk("lzdp_seg", 32'(seg1), 32'b1000000);
      chk("lzdp_dp", 32'(dpo1), 32'h0);

      // Forced blank
      load_all(16'h8888, 4'b0000, 4'b0010);
      wait_pos(1); chk("blk1_an", 32'(an0), 32'hF); chk("blk1_seg", 32'(seg0), 32'h7F);
      wait_pos(2); chk("blk2_seg", 32'(seg0), 32'b0000000);

      // Mid-slot reset on digit 2
      wait_pos(2);
      rst = 1'b1;
      tick();
      chk("mrst_an", 32'(an0), 32'hF); chk("mrst_seg", 32'(seg0), 32'h7F);
      chk("mrst_dp", 32'(dpo0), 32'h1);
      rst = 1'b0;
      tick();
      chk("mrst_dead", 32'(an0), 32'hF);
      tick();
      chk("mrst_an0", 32'(an0), 32'b1110); chk("mrst_seg0", 32'(seg0), 32'b1000000);
      chk("mrst_seg1", 32'(seg1), 32'b1000000);

      // Randomized traffic
      repeat (600) begin
         value = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
         dp    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         load  = ($urandom_range(0, 5) == 0);
         rst   = ($urandom_range(0, 59) == 0);
         tick();
      end
      rst = 1'b0; load = 1'b0;
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/seg7_mux.md
SEG7_MUX -- requirements
Module: seg7_mux

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 Parameter DIV, default 50000, clk cycles per digit slot (>=2).
REQ-003 Parameter LZ_BLANK, default 0, 1 = suppress leading zeros.
REQ-004 Port clk  input  1  the only clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port value  input  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 least significant.
REQ-007 Port dp  input  DIGITS  decimal-point request per digit, 1 = lit.
REQ-008 Port blank  input  DIGITS  per-digit force-off, 1 = digit dark.
REQ-009 Port load  input  1  single-cycle strobe that captures value/dp/blank into the shadow registers.
REQ-010 Port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 Port dp_out  output  1  decimal-point segment, active-low.
REQ-012 Port an  output  DIGITS  digit enables, active-low, at most one low at any time.

Function
REQ-013 Shadow registers SHALL capture value/dp/blank on the clk edge where load=1; the display SHALL use only shadow contents, never live inputs.
REQ-014 Divider counter SHALL count 0..DIV-1 and wrap; the digit index SHALL advance when the counter equals DIV-1.
REQ-015 The digit index SHALL wrap from DIGITS-1 to 0.
REQ-016 Dead cycle: for the first clk of each slot (counter==0), an SHALL be all 1s to prevent ghosting.
REQ-017 For counter 1..DIV-1, an[index] SHALL be 0 and all other an bits SHALL be 1.
REQ-018 seg, dp_out and an SHALL be registered outputs; they reflect index/counter state with exactly 1 clk latency.
REQ-019 Decode (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 A blanked digit SHALL drive seg=1111111 and dp_out=1, and SHALL keep its an bit high for the whole slot.
REQ-021 LZ_BLANK=1: digit i (i>0) SHALL be blanked when its shadow nibble and every higher-index nibble equal 0; digit 0 SHALL never be zero-suppressed.
REQ-022 Zero suppression SHALL NOT blank a digit whose shadow dp bit is 1.
REQ-023 dp_out SHALL equal ~dp_shadow[index] for non-blanked digits.
REQ-024 A load concurrent with a slot change SHALL be honoured; the new shadow contents SHALL appear on the next registered output update.
REQ-025 load SHALL NOT reset the divider counter or the digit index.

Reset
REQ-026 While rst=1 at a clk edge: counter=0, index=0, shadow value/dp/blank=0, seg=1111111, dp_out=1, an=all 1s.
REQ-027 rst SHALL take priority over load.
REQ-028 After rst deasserts, the first slot SHALL begin at counter=0 (dead cycle) on digit 0.
REQ-029 A reset asserted mid-slot SHALL force all outputs to the inactive state on the following edge.

Verification (DIGITS=4, DIV=4)
REQ-030 Reset then load value=16'h12AF, dp=0, blank=0 -> cycling order: an=1110 seg=0001110 (F); an=1101 seg=0001000 (A); an=1011 seg=0100100 (2); an=0111 seg=1111001 (1); each lit for 3 clks, preceded by one an=1111 cycle.
REQ-031 Hold load=0, toggle value after loading 16'h0005 -> display shows 0005 unchanged until the next load strobe.
REQ-032 LZ_BLANK=1, load 16'h0040, dp=0 -> digits 3 and 2 dark (an bit high, seg=1111111), digit 1 shows 4, digit 0 shows 0; then dp=4'b0100 -> digit 2 shows 0 with dp_out=0.
REQ-033 blank=4'b0010 with value 16'h8888 -> an[1] never low, other digits show 0000000.
REQ-034 Assert rst for 1 clk mid-slot on digit 2 -> next edge outputs inactive; after release, dead cycle then digit 0 shows 0 (shadow cleared).
REQ-035 Assertion across all tests: an never has more than one 0 bit, and an=all 1s whenever counter==0.
